// File: rtl/reg_write_sequencer_pkg.sv
// Shared definitions for the register-write sequencer: signal_generator register
// map, pattern entry layout and the playback state encoding.
package reg_write_sequencer_pkg;

    localparam logic [2:0] SG_ADDR_PERIOD_A = 3'd0;
    localparam logic [2:0] SG_ADDR_PERIOD_B = 3'd1;
    localparam logic [2:0] SG_ADDR_VOL_A    = 3'd2;
    localparam logic [2:0] SG_ADDR_VOL_B    = 3'd3;
    localparam logic [2:0] SG_ADDR_VOL_N    = 3'd4;
    localparam logic [2:0] SG_ADDR_ENABLES  = 3'd5;
    localparam logic [2:0] SG_ADDR_VIB      = 3'd6;

    localparam int DELAY_MSB = 15;
    localparam int DELAY_LSB = 8;
    localparam int ADDR_MSB  = 7;
    localparam int ADDR_LSB  = 5;
    localparam int DATA_MSB  = 4;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ISSUE = 2'd3
    } seq_state_e;

    function automatic logic [7:0] entry_delay(input logic [15:0] word);
        return word[DELAY_MSB:DELAY_LSB];
    endfunction

    function automatic logic [2:0] entry_addr(input logic [15:0] word);
        return word[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [4:0] entry_data(input logic [15:0] word);
        return word[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// held at zero while clear is high so every playback starts on a fresh phase.
module tick_prescaler #(
    parameter int TICK_DIV = 1000,
    parameter int TICK_W   = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST_COUNT = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count_r;

    // Divider counter: 0..TICK_DIV-1, wrapping after the tick cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_r <= {TICK_W{1'b0}};
        end else if (count_r == LAST_COUNT) begin
            count_r <= {TICK_W{1'b0}};
        end else begin
            count_r <= count_r + {{(TICK_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (count_r == LAST_COUNT);

endmodule

// File: rtl/reg_write_sequencer.sv
// Plays a loaded pattern of up to 16 timed register writes onto the
// signal_generator write bus (write_strobe/address/data).
module reg_write_sequencer
    import reg_write_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int TICK_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [15:0] load_word,
    input  logic [3:0]  length,
    input  logic        loop_en,
    input  logic        start,
    input  logic        stop,
    output logic        write_strobe,
    output logic [2:0]  address,
    output logic [4:0]  data,
    output logic        busy,
    output logic [3:0]  step_idx
);

    seq_state_e  state_r;
    seq_state_e  state_next_s;
    logic [15:0] pattern_r [16];
    logic [2:0]  entry_addr_r;
    logic [4:0]  entry_data_r;
    logic [7:0]  delay_cnt_r;
    logic [3:0]  step_r;
    logic [3:0]  last_r;
    logic [2:0]  addr_r;
    logic [4:0]  data_r;
    logic        tick_s;
    logic        clear_s;
    logic        issue_s;

    assign clear_s = (state_r == ST_IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // The write is cancelled in its own cycle by stop or rst, and a cancelled
    // write must leave the bus fields untouched, so they follow the strobe.
    assign issue_s      = (state_r == ST_ISSUE) && !stop && !rst;
    assign write_strobe = issue_s;
    assign address      = issue_s ? entry_addr_r : addr_r;
    assign data         = issue_s ? entry_data_r : data_r;
    assign busy         = (state_r != ST_IDLE);
    assign step_idx     = step_r;

    // Pattern memory: host writes accepted only while idle, never reset.
    always_ff @(posedge clk) begin
        if (load_en && (state_r == ST_IDLE)) begin
            pattern_r[load_addr] <= load_word;
        end
    end

    // Next-state decode; stop overrides every transition.
    always_comb begin
        state_next_s = state_r;
        if (stop) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = start ? ST_FETCH : ST_IDLE;
                ST_FETCH: state_next_s = ST_WAIT;
                ST_WAIT:  state_next_s = (delay_cnt_r == 8'd0) ? ST_ISSUE : ST_WAIT;
                ST_ISSUE: state_next_s = ((step_r != last_r) || loop_en) ? ST_FETCH : ST_IDLE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Step index and last-step bound; the bound is frozen when playback starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r <= 4'd0;
            last_r <= 4'd0;
        end else if ((state_r == ST_IDLE) && start && !stop) begin
            step_r <= 4'd0;
            last_r <= length;
        end else if (issue_s) begin
            if (step_r != last_r) begin
                step_r <= step_r + 4'd1;
            end else if (loop_en) begin
                step_r <= 4'd0;
            end else begin
                step_r <= step_r;
            end
        end else begin
            step_r <= step_r;
        end
    end

    // Entry latch and delay countdown; ticks only count while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_addr_r <= 3'd0;
            entry_data_r <= 5'd0;
            delay_cnt_r  <= 8'd0;
        end else if (state_r == ST_FETCH) begin
            entry_addr_r <= entry_addr(pattern_r[step_r]);
            entry_data_r <= entry_data(pattern_r[step_r]);
            delay_cnt_r  <= entry_delay(pattern_r[step_r]);
        end else if ((state_r == ST_WAIT) && tick_s && (delay_cnt_r != 8'd0)) begin
            delay_cnt_r <= delay_cnt_r - 8'd1;
        end
    end

    // Bus field hold registers, updated only by a write that actually issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= 3'd0;
            data_r <= 5'd0;
        end else if (issue_s) begin
            addr_r <= entry_addr_r;
            data_r <= entry_data_r;
        end
    end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Randomised bench for reg_write_sequencer; strobe times come from a timing model
// built from the playback rules (ticks every TDIV cycles from the first FETCH).
module tb_reg_write_sequencer;
    import reg_write_sequencer_pkg::*;

    localparam int TDIV = 4;

    typedef struct packed {
        int cyc;
        int addr;
        int data;
        int step;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst, load_en, loop_en, start, stop;
    logic [3:0]  load_addr, length, step_idx;
    logic [15:0] load_word;
    logic        write_strobe, busy;
    logic [2:0]  address;
    logic [4:0]  data;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_addr_m = 0;
    int   last_data_m = 0;
    ev_t  act_q[$];
    ev_t  exp_q[$];
    logic [15:0] mem_m [16];
    logic [4:0]  sg_regs [8];

    reg_write_sequencer #(.TICK_DIV(TDIV), .TICK_W(2)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_word(load_word), .length(length), .loop_en(loop_en),
        .start(start), .stop(stop), .write_strobe(write_strobe),
        .address(address), .data(data), .busy(busy), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus observer standing in for signal_generator's register file.
    always @(negedge clk) begin : mon
        ev_t e;
        if (write_strobe === 1'b1) begin
            e.cyc  = cyc;
            e.addr = int'(address);
            e.data = int'(data);
            e.step = int'(step_idx);
            act_q.push_back(e);
            sg_regs[address] <= data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic string fmt(input ev_t e);
        return $sformatf("cyc=%0d addr=%0d data=%0d step=%0d", e.cyc, e.addr, e.data, e.step);
    endfunction

    function automatic logic [15:0] rand_word(input int maxd);
        logic [7:0] d;
        logic [2:0] a;
        logic [4:0] v;
        d = 8'($urandom_range(maxd, 0));
        a = 3'($urandom);
        v = 5'($urandom);
        return {d, a, v};
    endfunction

    // Expected strobes: FETCH at f, d=0 issues at f+2; otherwise the d-th tick at
    // or after f+1 (ticks where (t-f0)%TDIV==TDIV-1) is followed 2 cycles later.
    function automatic void build_exp(input int f0, input int last, input int passes);
        int  f, t, d, w;
        ev_t e;
        f = f0;
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int s = 0; s <= last; s++) begin
                d = int'(mem_m[s][15:8]);
                if (d == 0) begin
                    t = f + 2;
                end else begin
                    w = f + 1;
                    t = w + (TDIV - 1 - ((w - f0) % TDIV)) + TDIV * (d - 1) + 2;
                end
                e.cyc  = t;
                e.addr = int'(mem_m[s][7:5]);
                e.data = int'(mem_m[s][4:0]);
                e.step = s;
                exp_q.push_back(e);
                f = t + 1;
            end
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int slot, input logic [15:0] w);
        load_en   = 1'b1;
        load_addr = slot[3:0];
        load_word = w;
        mem_m[slot] = w;
        next_cycle();
        load_en = 1'b0;
    endtask

    // Starts playback and waits for idle; optionally drops loop_en after the
    // first step of the second pass, and pokes load/start while busy.
    task automatic run_play(input int last, input bit lp, input bit inj, output bit to);
        int n;
        bit injected;
        n = 0;
        injected = 1'b0;
        to = 1'b0;
        act_q.delete();
        length  = last[3:0];
        loop_en = lp;
        start   = 1'b1;
        build_exp(cyc + 1, last, lp ? ((last == 0) ? 3 : 2) : 1);
        next_cycle();
        start = 1'b0;
        while (busy === 1'b1) begin
            load_en = 1'b0;
            start   = 1'b0;
            if (lp && act_q.size() >= last + 2) loop_en = 1'b0;
            if (inj && !injected && act_q.size() == 1) begin
                load_en   = 1'b1;
                load_addr = 4'd0;
                load_word = ~mem_m[0];
                start     = 1'b1;
                injected  = 1'b1;
            end
            next_cycle();
            n++;
            if (n > 3000) begin
                to = 1'b1;
                break;
            end
        end
        load_en = 1'b0;
        start   = 1'b0;
        loop_en = 1'b0;
        if (exp_q.size() > 0) begin
            last_addr_m = exp_q[$].addr;
            last_data_m = exp_q[$].data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_word = 16'd0;
        length = 4'd0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (write_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b, expected 0", write_strobe); end
        vectors++; if (address !== 3'd0) begin miscompares++; $display("FAIL reset_address: got %0d, expected 0", address); end
        vectors++; if (data !== 5'd0) begin miscompares++; $display("FAIL reset_data: got %0d, expected 0", data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        vectors++; if (step_idx !== 4'd0) begin miscompares++; $display("FAIL reset_step: got %0d, expected 0", step_idx); end
        next_cycle();
    endtask

    task automatic test_single();
        bit to;
        load(0, {8'd0, 3'd2, 5'd9});
        run_play(0, 1'b0, 1'b0, to);
        vectors++;
        if (to || act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL single_count: got %0d strobes (timeout=%0b), expected %0d", act_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_ev%0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i])); end
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b, expected 0", busy); end
        vectors++; if (sg_regs[SG_ADDR_VOL_A] !== 5'd9) begin miscompares++; $display("FAIL single_volA: got %0d, expected 9", sg_regs[SG_ADDR_VOL_A]); end
        vectors++; if (address !== 3'd2 || data !== 5'd9) begin miscompares++; $display("FAIL single_hold: got addr=%0d data=%0d, expected addr=2 data=9", address, data); end
        next_cycle();
    endtask

    task automatic test_delay();
        bit to;
        load(0, {8'd3, 3'($urandom), 5'($urandom)});
        load(1, {8'd0, 3'($urandom), 5'($urandom)});
        run_play(1, 1'b0, 1'b0, to);
        vectors++;
        if (to || act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL delay_count: got %0d strobes (timeout=%0b), expected %0d", act_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL delay_ev%0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i])); end
        end
        if (act_q.size() == 2) begin
            vectors++;
            if (act_q[1].cyc - act_q[0].cyc != 3) begin miscompares++; $display("FAIL delay_gap: got %0d cycles, expected 3", act_q[1].cyc - act_q[0].cyc); end
        end
    endtask

    task automatic test_loop();
        bit to;
        load(0, rand_word(3));
        load(1, rand_word(3));
        run_play(1, 1'b1, 1'b0, to);
        vectors++;
        if (to || act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL loop_count: got %0d strobes (timeout=%0b), expected %0d", act_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL loop_ev%0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i])); end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL loop_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_stop();
        load(0, {8'd0, 3'($urandom), 5'($urandom)});
        act_q.delete();
        length = 4'd0; loop_en = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        stop = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stop_running: got busy=%b, expected 1", busy); end
        vectors++; if (write_strobe !== 1'b0) begin miscompares++; $display("FAIL stop_strobe: got %b, expected 0", write_strobe); end
        vectors++; if (address !== 3'(last_addr_m) || data !== 5'(last_data_m)) begin
            miscompares++; $display("FAIL stop_bus: got addr=%0d data=%0d, expected addr=%0d data=%0d", address, data, last_addr_m, last_data_m);
        end
        next_cycle();
        stop = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_idle: got busy=%b, expected 0", busy); end
        vectors++; if (address !== 3'(last_addr_m) || data !== 5'(last_data_m)) begin
            miscompares++; $display("FAIL stop_hold: got addr=%0d data=%0d, expected addr=%0d data=%0d", address, data, last_addr_m, last_data_m);
        end
        next_cycle();
        start = 1'b1; stop = 1'b1;
        next_cycle();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL startstop_busy: got %b, expected 0", busy); end
        next_cycle();
        repeat (5) next_cycle();
        vectors++; if (act_q.size() != 0) begin miscompares++; $display("FAIL stop_nostrobe: got %0d strobes, expected 0", act_q.size()); end
    endtask

    task automatic test_busy_ignore();
        bit to;
        load(0, rand_word(2));
        load(1, rand_word(2));
        run_play(1, 1'b1, 1'b1, to);
        vectors++;
        if (to || act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL busy_count: got %0d strobes (timeout=%0b), expected %0d", act_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL busy_ev%0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i])); end
        end
    endtask

    task automatic test_rst();
        bit to;
        load(0, {8'd0, 3'($urandom), 5'($urandom)});
        act_q.delete();
        length = 4'd0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (write_strobe !== 1'b0) begin miscompares++; $display("FAIL rst_issue_strobe: got %b, expected 0", write_strobe); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if ({busy, address, data, step_idx} !== 13'd0) begin
            miscompares++; $display("FAIL rst_issue_outputs: got busy=%b addr=%0d data=%0d step=%0d, expected all 0", busy, address, data, step_idx);
        end
        next_cycle();
        load(0, {8'd3, 3'($urandom), 5'($urandom)});
        load(1, rand_word(2));
        load(2, rand_word(2));
        act_q.delete();
        length = 4'd2; start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if ({write_strobe, busy, address, data, step_idx} !== 14'd0) begin
            miscompares++; $display("FAIL rst_wait_outputs: got strobe=%b busy=%b addr=%0d data=%0d step=%0d, expected all 0", write_strobe, busy, address, data, step_idx);
        end
        vectors++; if (act_q.size() != 0) begin miscompares++; $display("FAIL rst_wait_nostrobe: got %0d strobes, expected 0", act_q.size()); end
        next_cycle();
        run_play(2, 1'b0, 1'b0, to);
        vectors++;
        if (to || act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rst_replay_count: got %0d strobes (timeout=%0b), expected %0d", act_q.size(), to, exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rst_replay_ev%0d: got %s, expected %s", i, fmt(act_q[i]), fmt(exp_q[i])); end
        end
    endtask

    task automatic test_random();
        bit to;
        int last;
        bit lp;
        for (int it = 0; it < 5; it++) begin
            last = (it == 0) ? 15 : int'($urandom_range(15, 0));
            lp   = (it == 0) ? 1'b1 : ((it == 1) ? 1'b1 : 1'($urandom));
            if (it == 1) last = 0;
            for (int s = 0; s < 16; s++) load(s, rand_word(3));
            run_play(last, lp, 1'b0, to);
            vectors++;
            if (to || act_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL random%0d_count: got %0d strobes (timeout=%0b), expected %0d", it, act_q.size(), to, exp_q.size());
            end
            foreach (exp_q[i]) if (i < act_q.size()) begin
                vectors++;
                if (act_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL random%0d_ev%0d: got %s, expected %s", it, i, fmt(act_q[i]), fmt(exp_q[i])); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_delay();
        test_loop();
        test_stop();
        test_busy_ignore();
        test_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
